// File: rtl/hash_arb_pkg.sv
// hash_arb_pkg: shared widths, FSM state type and name-chunk length masking for the hash request arbiter
package hash_arb_pkg;
  localparam int NAME_W = 64;
  localparam int LEN_W = 6;
  localparam int HASH_W = 10;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {WARM, IDLE, BUSY, RESP} state_t;
  function automatic logic [NAME_W-1:0] mask_chunk(input logic [NAME_W-1:0] d, input logic [LEN_W-1:0] len);
    return len == '0 ? d : d & ((NAME_W'(1) << len) - NAME_W'(1));
  endfunction
endpackage

// File: rtl/hash_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr (wrapping) -> one-hot gnt, idx, any
module rr_pick
  import hash_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  int off;
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = 0;
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = i;
    any = |req;
    idx = ID_W'((int'(ptr) + off) % N_REQ);
    gnt = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/hash_req_arbiter.sv
// hash_req_arbiter: round-robin share of one name-hash engine among N_REQ requesters, one job in flight; HASH_ARB_STATS_EN adds stat_grants counters
module hash_req_arbiter
  import hash_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int HASH_LAT = 1,
  parameter int WARM_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*NAME_W-1:0] req_data,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_ready,
  output logic [NAME_W-1:0]       hash_data,
  output logic [LEN_W-1:0]        hash_len,
  input  logic [HASH_W-1:0]       hash_result,
  output logic                    rsp_valid,
  output logic [HASH_W-1:0]       rsp_hash,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy
`ifdef HASH_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     stat_grants
`endif
);
  state_t state;
  logic [7:0] warm_cnt;
  logic [2:0] lat;
  logic [ID_W-1:0] rr, g_idx;
  logic [N_REQ-1:0] g_hot;
  logic g_any, acc;
  rr_pick #(.N_REQ(N_REQ)) u_pick (.req(req_valid), .ptr(rr), .gnt(g_hot), .idx(g_idx), .any(g_any));
  assign acc = state == IDLE && g_any;
  assign req_ready = acc ? g_hot : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WARM;
      warm_cnt <= '0;
      lat <= '0;
      rr <= '0;
      hash_data <= '0;
      hash_len <= '0;
      rsp_hash <= '0;
      rsp_id <= '0;
    end else begin
      case (state)
        WARM: begin
          warm_cnt <= warm_cnt + 8'd1;
          if (int'(warm_cnt) >= WARM_CYC - 1) state <= IDLE;
        end
        IDLE: if (g_any) begin
          hash_data <= mask_chunk(req_data[NAME_W*g_idx +: NAME_W], req_len[LEN_W*g_idx +: LEN_W]);
          hash_len <= req_len[LEN_W*g_idx +: LEN_W];
          rsp_id <= g_idx;
          rr <= ID_W'((int'(g_idx) + 1) % N_REQ);
          lat <= 3'(HASH_LAT);
          state <= BUSY;
        end
        BUSY: begin
          lat <= lat - 3'd1;
          if (lat == 3'd1) begin
            rsp_hash <= hash_result;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= WARM;
      endcase
    end
  end
`ifdef HASH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) stat_grants[16*i +: 16] <= '0;
      else if (acc && g_hot[i] && stat_grants[16*i +: 16] != 16'hFFFF) stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hash_req_arbiter.sv
// tb_hash_req_arbiter: directed scoreboard bench for hash_req_arbiter with a combinational fold-hash engine model
module tb_hash_req_arbiter;
  logic clk = 0;
  logic rst;
  logic [3:0] req_valid, req_ready;
  logic [255:0] req_data;
  logic [23:0] req_len;
  logic [63:0] hash_data;
  logic [5:0] hash_len;
  logic [9:0] hash_result, rsp_hash;
  logic rsp_valid, rsp_ready, busy;
  logic [2:0] rsp_id;
`ifdef HASH_ARB_STATS_EN
  logic [63:0] stat_grants;
`endif
  logic [63:0] d [4];
  logic [5:0] l [4];
  logic [63:0] m [4];
  logic [12:0] q [$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [9:0] fold(input logic [63:0] x);
    return x[9:0] ^ x[19:10] ^ x[29:20] ^ x[39:30] ^ x[49:40] ^ x[59:50] ^ {6'b0, x[63:60]};
  endfunction
  assign hash_result = fold(hash_data);
  always_comb begin
    req_data = '0;
    req_len = '0;
    for (int i = 0; i < 4; i++) begin
      req_data[64*i +: 64] = d[i];
      req_len[6*i +: 6] = l[i];
    end
  end
  hash_req_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_len(req_len),
    .req_ready(req_ready), .hash_data(hash_data), .hash_len(hash_len), .hash_result(hash_result),
    .rsp_valid(rsp_valid), .rsp_hash(rsp_hash), .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
`ifdef HASH_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input int i);
    q.push_back({3'(i), fold(m[i])});
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask
  task automatic job(input logic [3:0] rv, input int id);
    @(negedge clk);
    req_valid = rv;
    #1;
    chk("job_grant", 64'(req_ready), 64'(4'b1 << id));
    push(id);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("job_hash_data", hash_data, m[id]);
    chk("job_hash_len", 64'(hash_len), 64'(l[id]));
  endtask
  always @(negedge clk) begin
    logic [12:0] e;
    #3;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got id %0d hash %h expected no response", rsp_id, rsp_hash);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e[12:10]));
        chk("rsp_hash", 64'(rsp_hash), 64'(e[9:0]));
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1;
    req_valid = '0;
    rsp_ready = 1;
    d[0] = 64'h0123_4567_89AB_CDEF; l[0] = 6'd0;  m[0] = 64'h0123_4567_89AB_CDEF;
    d[1] = 64'hFEDC_BA98_7654_3210; l[1] = 6'd16; m[1] = 64'h0000_0000_0000_3210;
    d[2] = 64'hFFFF_FFFF_FFFF_FFFF; l[2] = 6'd8;  m[2] = 64'h0000_0000_0000_00FF;
    d[3] = 64'hA5A5_A5A5_A5A5_A5A5; l[3] = 6'd63; m[3] = 64'h25A5_A5A5_A5A5_A5A5;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_hash_data", hash_data, 64'd0);
    chk("rst_hash_len", 64'(hash_len), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_hash", 64'(rsp_hash), 64'd0);
    @(negedge clk);
    rst = 0;
    req_valid = 4'b0001;
    #1;
    chk("warm_cyc1", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("warm_cyc2", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("first_grant", 64'(req_ready), 64'b0001);
    push(0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("first_hash_data", hash_data, m[0]);
    wait_idle();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    req_valid = 4'b1111;
    @(negedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      #1;
      chk("rr_grant", 64'(req_ready), 64'(4'b1 << (j % 4)));
      push(j % 4);
      @(negedge clk);
      #1;
      chk("rr_busy_no_grant", 64'(req_ready), 64'd0);
      chk("rr_busy_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("rr_resp_valid", 64'(rsp_valid), 64'd1);
      chk("rr_resp_no_grant", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_idle();
    job(4'b0100, 2);
    wait_idle();
    l[2] = 6'd0;
    m[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    job(4'b0100, 2);
    wait_idle();
    rsp_ready = 0;
    job(4'b1000, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_id", 64'(rsp_id), 64'd3);
      chk("hold_rsp_hash", 64'(rsp_hash), 64'(fold(m[3])));
      chk("hold_no_grant", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1;
    #1;
    chk("hold_release_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    #1;
    chk("resume_grant", 64'(req_ready), 64'b0001);
    push(0);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_idle();
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    rst = 1;
    #1;
    @(negedge clk);
    #1;
    chk("midjob_rst_no_rsp", 64'(rsp_valid), 64'd0);
    chk("midjob_rst_busy", 64'(busy), 64'd1);
    chk("midjob_rst_hash_data", hash_data, 64'd0);
    @(negedge clk);
    rst = 0;
    req_valid = 4'b0110;
    #1;
    chk("post_rst_warm1", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("post_rst_warm2", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("post_rst_grant_lowest", 64'(req_ready), 64'b0010);
    push(1);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
